// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Constants shared by the Morse capture path (morse_receiver) and the Morse
// serializer: symbol encodings, code-word geometry and the receiver FSM states.
// A code word is CODE_W bits made of MAX_SYMS two-bit symbol pairs, filled
// MSB-first starting at bits [9:8]; unused pairs are SYM_NONE.
// -----------------------------------------------------------------------------
package morse_pkg;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b10;
    localparam logic [1:0] SYM_DASH = 2'b11;

    localparam int MAX_SYMS = 5;
    localparam int CODE_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    // Returns word with symbol pair number idx (0 = bits [9:8]) set to sym.
    function automatic logic [CODE_W-1:0] place_sym(
        input logic [CODE_W-1:0] word,
        input logic [2:0]        idx,
        input logic [1:0]        sym
    );
        logic [CODE_W-1:0] r_res;
        r_res = word;
        for (int i = 0; i < MAX_SYMS; i++) begin
            if (idx == 3'(i)) begin
                r_res[CODE_W-1-2*i -: 2] = sym;
            end
        end
        return r_res;
    endfunction

endpackage

// File: rtl/key_sync.sv
// -----------------------------------------------------------------------------
// key_sync
// Two-flop synchronizer for the asynchronous key line plus an edge detector
// that compares the synchronized level against its previous value.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset (all flops clear to 0)
//   key    in   raw key level, 1 = pressed, asynchronous to clk
//   key_s  out  synchronized key level (2 clk latency)
//   rise   out  key_s went 0->1 this cycle (combinational from flops)
//   fall   out  key_s went 1->0 this cycle (combinational from flops)
// -----------------------------------------------------------------------------
module key_sync (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= key;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign key_s = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/morse_receiver.sv
// -----------------------------------------------------------------------------
// morse_receiver
// Times key presses and releases against the tick strobe, classifies each
// press as dot or dash and packs a letter into a 10-bit code word (two bits
// per symbol, MSB-first). A release lasting GAP_TICKS ticks ends the letter.
// Ports:
//   clk        in   system clock (single domain)
//   reset      in   asynchronous, active-low reset
//   tick       in   one-clk timing strobe
//   key        in   raw key level, 1 = pressed, asynchronous
//   code       out  last captured letter
//   len        out  symbol count of code (0..5)
//   valid      out  one-cycle pulse when code/len/err update
//   err        out  last letter had more than 5 symbols
//   dbg_state  out  current FSM state, for observation only
// Output protocol: valid is a push-only strobe with no back-pressure; code,
// len and err change in the same cycle valid is high and then hold until the
// next emission.
// -----------------------------------------------------------------------------
module morse_receiver
    import morse_pkg::*;
#(
    parameter int DASH_TICKS = 3,
    parameter int GAP_TICKS  = 3,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              key,
    output logic [CODE_W-1:0] code,
    output logic [2:0]        len,
    output logic              valid,
    output logic              err,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_TICKS);
    localparam logic [2:0]       MAX_N   = 3'(MAX_SYMS);

    logic w_key_s;
    logic w_rise;
    logic w_fall;

    key_sync u_key_sync (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .key_s (w_key_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt,   w_cnt;
    logic [CODE_W-1:0] r_word,  w_word;
    logic [2:0]        r_n,     w_n;
    logic              r_ovf,   w_ovf;
    logic [CODE_W-1:0] r_code,  w_code;
    logic [2:0]        r_len,   w_len;
    logic              r_err,   w_err;
    logic              r_valid, w_valid;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic [1:0]        w_sym;

    // Saturating increment: a very long press must stay a dash.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    // Zero-tick presses fall below DASH_C and are dots.
    assign w_sym     = (r_cnt >= DASH_C) ? SYM_DASH : SYM_DOT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_n     <= '0;
            r_ovf   <= 1'b0;
            r_code  <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_word  <= w_word;
            r_n     <= w_n;
            r_ovf   <= w_ovf;
            r_code  <= w_code;
            r_len   <= w_len;
            r_err   <= w_err;
            r_valid <= w_valid;
        end
    end

    // Key edges are tested before tick in every state, so an edge coinciding
    // with a tick restarts cnt and that tick is dropped.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_word  = r_word;
        w_n     = r_n;
        w_ovf   = r_ovf;
        w_code  = r_code;
        w_len   = r_len;
        w_err   = r_err;
        w_valid = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state = MARK;
                    w_cnt   = '0;
                end
            end

            MARK: begin
                if (w_fall) begin
                    if (r_n < MAX_N) begin
                        w_word = place_sym(r_word, r_n, w_sym);
                        w_n    = r_n + 3'd1;
                    end else begin
                        w_ovf  = 1'b1;
                    end
                    w_state = SPACE;
                    w_cnt   = '0;
                end else if (tick) begin
                    w_cnt = w_cnt_inc;
                end
            end

            SPACE: begin
                if (w_rise) begin
                    w_state = MARK;
                    w_cnt   = '0;
                end else if (tick) begin
                    if (w_cnt_inc == GAP_C) begin
                        w_code  = r_word;
                        w_len   = r_n;
                        w_err   = r_ovf;
                        w_valid = 1'b1;
                        w_word  = '0;
                        w_n     = '0;
                        w_ovf   = 1'b0;
                        w_cnt   = '0;
                        w_state = IDLE;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    assign code      = r_code;
    assign len       = r_len;
    assign err       = r_err;
    assign valid     = r_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_morse_receiver.sv
module tb_morse_receiver;
    import morse_pkg::*;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        key;
    logic [9:0]  code;
    logic [2:0]  len;
    logic        valid;
    logic        err;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    // valid pulses seen, and the outputs captured during the latest pulse
    int          vcnt = 0;
    logic [9:0]  cap_code = '0;
    logic [2:0]  cap_len  = '0;
    logic        cap_err  = 1'b0;

    morse_receiver #(
        .DASH_TICKS (3),
        .GAP_TICKS  (3),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .key       (key),
        .code      (code),
        .len       (len),
        .valid     (valid),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // valid monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt     <= vcnt + 1;
            cap_code <= code;
            cap_len  <= len;
            cap_err  <= err;
        end
    end

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n ticks, each preceded by 6 quiet cycles so key edges settle first
    task automatic ticks(input int n);
        repeat (n) begin
            cycles(6);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic press(input int t);
        key = 1'b1;
        ticks(t);
    endtask

    task automatic release_for(input int t);
        key = 1'b0;
        ticks(t);
    endtask

    task automatic expect_letter(input string tag, input int v0,
                                 input logic [9:0] e_code, input logic [2:0] e_len,
                                 input logic e_err);
        cycles(3);
        check({tag, "_nvalid"}, 10'(vcnt - v0), 10'd1);
        check({tag, "_code"},   cap_code, e_code);
        check({tag, "_len"},    10'(cap_len), 10'(e_len));
        check({tag, "_err"},    10'(cap_err), 10'(e_err));
        check({tag, "_state"},  10'(dbg_state), 10'(IDLE));
    endtask

    int v0;

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        key   = 1'b0;

        // reset held 5 cycles with key toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key = ~key;
            check("rst_code",  code, 10'd0);
            check("rst_len",   10'(len), 10'd0);
            check("rst_valid", 10'(valid), 10'd0);
            check("rst_err",   10'(err), 10'd0);
        end
        key = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycles(5);
        check("post_rst_state", 10'(dbg_state), 10'(IDLE));
        check("post_rst_nvalid", 10'(vcnt), 10'd0);

        // single dot
        v0 = vcnt;
        press(1);
        release_for(3);
        expect_letter("dot", v0, 10'b1000000000, 3'd1, 1'b0);

        // outputs hold between letters
        cycles(20);
        check("hold_code", code, 10'b1000000000);
        check("hold_nvalid", 10'(vcnt - v0), 10'd1);

        // letter A: dot, gap 1, dash of 4
        v0 = vcnt;
        press(1);
        release_for(1);
        press(4);
        release_for(3);
        expect_letter("A", v0, 10'b1011000000, 3'd2, 1'b0);

        // five dashes of exactly DASH_TICKS
        v0 = vcnt;
        for (int i = 0; i < 5; i++) begin
            press(3);
            release_for(1);
        end
        ticks(2);
        expect_letter("dash5", v0, 10'b1111111111, 3'd5, 1'b0);

        // six dots: overflow
        v0 = vcnt;
        for (int i = 0; i < 6; i++) begin
            press(1);
            release_for(1);
        end
        ticks(2);
        expect_letter("dot6", v0, 10'b1010101010, 3'd5, 1'b1);

        // key rise coinciding with the tick that would end the letter
        v0 = vcnt;
        press(1);
        release_for(2);
        key = 1'b1;            // rise seen by FSM at the 3rd posedge from here
        cycles(2);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cycles(2);
        check("coinc_nvalid", 10'(vcnt - v0), 10'd0);
        check("coinc_state", 10'(dbg_state), 10'(MARK));
        ticks(3);
        release_for(3);
        expect_letter("coinc", v0, 10'b1011000000, 3'd2, 1'b0);

        // saturating counter: very long press stays a dash
        v0 = vcnt;
        press(20);
        release_for(3);
        expect_letter("long", v0, 10'b1100000000, 3'd1, 1'b0);

        // reset mid-MARK, key released while reset still held
        v0 = vcnt;
        press(2);
        reset = 1'b0;
        cycles(2);
        key = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ticks(5);
        check("midrst_nvalid", 10'(vcnt - v0), 10'd0);
        check("midrst_code",   code, 10'd0);
        check("midrst_len",    10'(len), 10'd0);
        check("midrst_err",    10'(err), 10'd0);
        check("midrst_state",  10'(dbg_state), 10'(IDLE));

        // letter N after the reset
        v0 = vcnt;
        press(3);
        release_for(1);
        press(1);
        release_for(3);
        expect_letter("N", v0, 10'b1110000000, 3'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_receiver.md
# morse_receiver

Morse key receiver: samples a single Morse key line, times each press and release against a slow tick strobe, classifies presses as dot or dash, and packs a letter into the same 10-bit, 2-bit-per-symbol code word that the Morse serializer consumes. Sits between the debounced key input and the letter-decode/display logic. It is the capture side of the existing Morse output path.

## Interface
- `DASH_TICKS`, default 3: press of ≥ this many ticks is a dash; shorter is a dot.
- `GAP_TICKS`, default 3: release of this many ticks ends the letter.
- `CNT_W`, default 4: tick counter width. Saturates at 2^CNT_W−1; `DASH_TICKS` and `GAP_TICKS` must be ≤ that value.
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-`clk` strobe from the time-base divider; this is the timing unit.
- `key`, in, 1: key level, 1 = pressed; asynchronous to `clk`.
- `code`, out, 10: last captured letter, MSB-first symbol pairs.
- `len`, out, 3: symbol count of `code`, range 0–5.
- `valid`, out, 1: single-cycle pulse when `code`/`len`/`err` update.
- `err`, out, 1: last letter had more than 5 symbols.

## Operation
- Symbol encoding, per pair starting at bits [9:8]:
  - `11` = dash
  - `10` = dot
  - `00` = empty; all pairs after the last symbol are `00`.
- `key` passes through a 2-flop synchronizer into `key_s`, then an edge detector against the previous `key_s`.
- Internal state: `word` (10 b), `n` (3 b), `ovf`, `cnt` (CNT_W, saturating).
- State machine:
  - IDLE: on a rise of `key_s`, go to MARK with `cnt=0`. Ticks are ignored.
  - MARK: each `tick` increments `cnt`. On a fall of `key_s`, classify: `cnt≥DASH_TICKS` is a dash, otherwise a dot (a zero-tick press is a dot).
    - If `n<5`, write the symbol into pair `n` and increment `n`.
    - Otherwise set `ovf`.
    - Then go to SPACE with `cnt=0`.
  - SPACE: each `tick` increments `cnt`.
    - Rise of `key_s`: go to MARK with `cnt=0` (intra-letter gap).
    - Tick taking `cnt` to `GAP_TICKS`: emit the letter (`code←word`, `len←n`, `err←ovf`, `valid←1`), clear `word`, `n` and `ovf`, and go to IDLE.
- Simultaneous `key_s` edge and `tick`: the edge wins. `cnt` resets to 0 and the tick is not counted.
- `code`, `len` and `err` hold between emissions.

## Timing
- Reset (asynchronous assert): `code=0`, `len=0`, `valid=0`, `err=0`, state IDLE, synchronizer flops at 0.
- `key` to `key_s`: 2 `clk` cycles. The edge is acted on at the next `clk` edge, so 3 cycles from `key` change to the state change.
- `valid` is high for exactly the one cycle after the emitting tick's `clk` edge. `code`, `len` and `err` change in that same cycle.
- Reset asserted mid-letter: the partial letter is discarded and no `valid` is produced afterwards.
- If the key is held at reset release, the synchronizer starts at 0, so the first rise is seen and the letter is captured normally.
- `cnt` saturates; a long MARK stays a dash.

## Structure
- Shared package/include `morse_pkg`:
  - `SYM_DOT=2'b10`, `SYM_DASH=2'b11`, `SYM_NONE=2'b00`
  - `MAX_SYMS=5`, `CODE_W=10`
  - state encodings IDLE/MARK/SPACE
- The serializer uses the same constants.
- Sub-module `key_sync`: 2-flop synchronizer plus rise/fall pulse outputs, with asynchronous active-low reset.

## Test plan
- Reset low for 5 cycles with `key` toggling: `code=0`, `len=0`, `valid=0`, `err=0` throughout.
- Press 1 tick, release 3 ticks: one `valid` pulse, `code=10'b1000000000`, `len=1`, `err=0`.
- Letter "A" (press 1 tick, gap 1 tick, press 4 ticks, release 3 ticks): `code=10'b1011000000`, `len=2`.
- Five dashes: `code=10'b1111111111`, `len=5`, `err=0`. Six dots: `code=10'b1010101010`, `len=5`, `err=1`.
- `key` rise in the same cycle as `tick` during SPACE with `cnt=GAP_TICKS−1`: no emission, the press continues in MARK, and the next letter includes both symbols.
- Reset pulsed mid-MARK, then `key` released: no `valid`, all outputs 0. The next full letter captures correctly.
